// File: rtl/narrow_ram_reader_pkg.sv
// Shared types and width helpers for the narrow RAM reader.
// FSM state encoding plus LOG / NAW derivation.
package narrow_ram_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   function automatic int log_f(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int naw_f(input int aw, input int n);
      return aw + log_f(n);
   endfunction

endpackage

// File: rtl/narrow_ram_skid.sv
// Two-entry skid buffer between the RAM read stage and dout.
// Entry 0 is the registered output; entry 1 absorbs a stall.
module narrow_ram_skid
   import narrow_ram_reader_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         full
);

   logic         v0_q, v0_d;
   logic         v1_q, v1_d;
   logic [W-1:0] d0_q, d0_d;
   logic [W-1:0] d1_q, d1_d;
   logic         push;
   logic         pop;

   assign in_ready  = !v1_q;
   assign out_valid = v0_q;
   assign out_data  = d0_q;
   assign full      = v1_q;
   assign push      = in_valid && !v1_q;
   assign pop       = v0_q && out_ready;

   // Refill the output entry from the skid entry first, then input.
   always_comb begin
      v0_d = v0_q;
      v1_d = v1_q;
      d0_d = d0_q;
      d1_d = d1_q;
      if (pop || !v0_q) begin
         if (v1_q) begin
            v0_d = 1'b1;
            d0_d = d1_q;
            v1_d = 1'b0;
         end else begin
            v0_d = push;
            if (push) d0_d = in_data;
         end
      end else if (push) begin
         v1_d = 1'b1;
         d1_d = in_data;
      end
   end

   // Entry registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         v0_q <= 1'b0;
         v1_q <= 1'b0;
         d0_q <= '0;
         d1_q <= '0;
      end else begin
         v0_q <= v0_d;
         v1_q <= v1_d;
         d0_q <= d0_d;
         d1_q <= d1_d;
      end
   end

endmodule

// File: rtl/narrow_ram_reader.sv
// Wide-write RAM read back as a burst of narrow words.
// Define NARROW_RAM_READER_ERR_EN to reject bursts past the end.
module narrow_ram_reader
   import narrow_ram_reader_pkg::*;
#(
   parameter  int DIN_WIDTH       = 32,
   parameter  int N_DIN_TO_DOUT   = 4,
   parameter  int DOUT_ADDR_WIDTH = 10,
   localparam int LOG = log_f(N_DIN_TO_DOUT),
   localparam int NAW = naw_f(DOUT_ADDR_WIDTH, N_DIN_TO_DOUT)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [N_DIN_TO_DOUT*DIN_WIDTH-1:0] write_data,
   input  logic [DOUT_ADDR_WIDTH-1:0]         write_addr,
   input  logic                               write_enable,
   input  logic                               start,
   input  logic [NAW-1:0]                     start_addr,
   input  logic [NAW:0]                       length,
   output logic                               busy,
`ifdef NARROW_RAM_READER_ERR_EN
   output logic                               err,
`endif
   output logic [DIN_WIDTH-1:0]               dout_data,
   output logic                               dout_valid,
   input  logic                               dout_ready,
   output logic                               done
);

   typedef logic [N_DIN_TO_DOUT-1:0][DIN_WIDTH-1:0] wide_t;

   localparam logic [NAW-1:0] A_ONE = 1;
   localparam logic [NAW:0]   L_ONE = 1;

   wide_t          mem [2**DOUT_ADDR_WIDTH];
   wide_t          ram_rd_q;

   state_e         state_q, state_d;
   logic [NAW-1:0] addr_q, addr_d;
   logic [NAW:0]   rem_q, rem_d;
   logic           done_q, done_d;
   logic           rd_valid_q, rd_valid_d;
   logic [LOG-1:0] rd_lane_q, rd_lane_d;
   logic [NAW-1:0] rd_addr;
   logic           issue;
   logic           rd_free;
   logic           skid_ready;
   logic           skid_full;
   logic           final_xfer;

`ifdef NARROW_RAM_READER_ERR_EN
   logic           err_q, err_d;
   logic [NAW+1:0] end_addr;
   logic           range_err;

   assign end_addr  = {2'b00, start_addr} + {1'b0, length};
   assign range_err = end_addr > {2'b01, {NAW{1'b0}}};
   assign err       = err_q;
`endif

   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign rd_free    = !rd_valid_q || skid_ready;
   assign final_xfer = dout_valid && dout_ready
                    && !skid_full && !rd_valid_q;

   // Burst FSM: issue one narrow address per cycle while room.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      done_d     = 1'b0;
`ifdef NARROW_RAM_READER_ERR_EN
      err_d      = 1'b0;
`endif
      issue      = 1'b0;
      rd_addr    = addr_q;
      unique case (state_q)
         ST_IDLE: begin
            rd_addr = start_addr;
            if (start) begin
               if (length == '0) begin
                  done_d = 1'b1;
`ifdef NARROW_RAM_READER_ERR_EN
               end else if (range_err) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
`endif
               end else begin
                  issue   = 1'b1;
                  addr_d  = start_addr + A_ONE;
                  rem_d   = length - L_ONE;
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (rem_q == '0) begin
               state_d = ST_DRAIN;
            end else if (rd_free) begin
               issue  = 1'b1;
               addr_d = addr_q + A_ONE;
               rem_d  = rem_q - L_ONE;
               if (rem_q == L_ONE) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (final_xfer) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rd_valid_d = issue || (rd_valid_q && !skid_ready);
      rd_lane_d  = issue ? rd_addr[LOG-1:0] : rd_lane_q;
   end

   // RAM: read-before-write, read port only clocks on issue.
   always_ff @(posedge clk) begin
      if (write_enable) mem[write_addr] <= write_data;
      if (issue) ram_rd_q <= mem[rd_addr[NAW-1:LOG]];
   end

   // Control and read-stage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_lane_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
         rd_lane_q  <= rd_lane_d;
      end
   end

`ifdef NARROW_RAM_READER_ERR_EN
   // Error pulse register.
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end
`endif

   narrow_ram_skid #(
      .W (DIN_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_valid_q),
      .in_ready  (skid_ready),
      .in_data   (ram_rd_q[rd_lane_q]),
      .out_valid (dout_valid),
      .out_ready (dout_ready),
      .out_data  (dout_data),
      .full      (skid_full)
   );

endmodule

// File: tb/tb_narrow_ram_reader.sv
// Directed self-checking bench for narrow_ram_reader.
// Covers NARROW_RAM_READER_ERR_EN builds as well.
module tb_narrow_ram_reader;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] write_data;
   logic [9:0]   write_addr;
   logic         write_enable;
   logic         start;
   logic [11:0]  start_addr;
   logic [12:0]  length;
   logic         busy;
   logic [31:0]  dout_data;
   logic         dout_valid;
   logic         dout_ready;
   logic         done;
`ifdef NARROW_RAM_READER_ERR_EN
   logic         err;
`endif

   int           n_chk  = 0;
   int           n_pass = 0;
   logic [31:0]  model [4096];

   always #5 clk = ~clk;

   narrow_ram_reader dut (
      .clk          (clk),
      .rst          (rst),
      .write_data   (write_data),
      .write_addr   (write_addr),
      .write_enable (write_enable),
      .start        (start),
      .start_addr   (start_addr),
      .length       (length),
      .busy         (busy),
`ifdef NARROW_RAM_READER_ERR_EN
      .err          (err),
`endif
      .dout_data    (dout_data),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .done         (done)
   );

   function automatic logic rdy(input int mode, input int cyc);
      if (mode == 1) begin
         case ((cyc - 1) % 6)
            0, 3, 5: return 1'b1;
            default: return 1'b0;
         endcase
      end
      if (mode == 2) return (cyc >= 8);
      return 1'b1;
   endfunction

   task automatic write_wide(input logic [9:0] a, input logic [127:0] d);
      write_addr   = a;
      write_data   = d;
      write_enable = 1'b1;
      @(posedge clk); #1;
      write_enable = 1'b0;
      for (int i = 0; i < 4; i++) model[{a, 2'(i)}] = d[i*32 +: 32];
   endtask

   task automatic run_burst(input logic [11:0] sa, input logic [12:0] len,
                            input int mode, input bit poke, input string nm);
      int          got = 0;
      int          first_v = -1;
      int          last_x = -1;
      int          done_cyc = -1;
      int          ndone = 0;
      bit          stall = 0;
      logic [31:0] held = '0;
      logic [11:0] ea;
      start      = 1'b1;
      start_addr = sa;
      length     = len;
      dout_ready = 1'b1;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 1) begin
            start = 1'b0;
            n_chk++;
            if (busy !== (len != 0))
               $display("FAIL %s busy_after_start: got %b expected %b",
                        nm, busy, (len != 0));
            else n_pass++;
         end
         if (poke && cyc == 3) begin
            start      = 1'b1;
            start_addr = sa + 12'd100;
            length     = 13'd5;
         end else if (poke && cyc == 4) begin
            start = 1'b0;
         end
         if (stall) begin
            n_chk++;
            if (dout_valid !== 1'b1 || dout_data !== held)
               $display("FAIL %s stall_hold: got %b/%h expected 1/%h",
                        nm, dout_valid, dout_data, held);
            else n_pass++;
         end
         dout_ready = rdy(mode, cyc);
         if (dout_valid === 1'b1 && first_v < 0) first_v = cyc;
         if (done === 1'b1) begin
            ndone++;
            if (done_cyc < 0) done_cyc = cyc;
            n_chk++;
            if (busy !== 1'b0)
               $display("FAIL %s busy_at_done: got %b expected 0", nm, busy);
            else n_pass++;
         end
         if (dout_valid === 1'b1 && dout_ready) begin
            ea = sa + 12'(got);
            n_chk++;
            if (dout_data !== model[ea])
               $display("FAIL %s word%0d: got %h expected %h",
                        nm, got, dout_data, model[ea]);
            else n_pass++;
            got++;
            last_x = cyc;
         end
         stall = (dout_valid === 1'b1) && !dout_ready;
         held  = dout_data;
         if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      end
      dout_ready = 1'b1;
      n_chk++;
      if (got != int'(len))
         $display("FAIL %s word_count: got %0d expected %0d", nm, got, len);
      else n_pass++;
      n_chk++;
      if (ndone != 1)
         $display("FAIL %s done_pulses: got %0d expected 1", nm, ndone);
      else n_pass++;
      n_chk++;
      if (done_cyc != ((len == 0) ? 1 : last_x + 1))
         $display("FAIL %s done_cycle: got %0d expected %0d",
                  nm, done_cyc, (len == 0) ? 1 : last_x + 1);
      else n_pass++;
      n_chk++;
      if (first_v != ((len == 0) ? -1 : 2))
         $display("FAIL %s first_valid_cycle: got %0d expected %0d",
                  nm, first_v, (len == 0) ? -1 : 2);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
      else n_pass++;
      n_chk++;
      if (dout_valid !== 1'b0)
         $display("FAIL reset_valid: got %b expected 0", dout_valid);
      else n_pass++;
      n_chk++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
      else n_pass++;
      n_chk++;
      if (dout_data !== 32'h0)
         $display("FAIL reset_data: got %h expected 0", dout_data);
      else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      write_wide(10'd0,    {32'hD3D3_0003, 32'hD2D2_0002,
                            32'hD1D1_0001, 32'hD0D0_0000});
      write_wide(10'd1,    {32'h1717_0007, 32'h1616_0006,
                            32'h1515_0005, 32'h1414_0004});
      write_wide(10'd2,    {32'h2B2B_000B, 32'h2A2A_000A,
                            32'h2929_0009, 32'h2828_0008});
      write_wide(10'd3,    {32'h3F3F_000F, 32'h3E3E_000E,
                            32'h3D3D_000D, 32'h3C3C_000C});
      write_wide(10'd1023, {32'hFFFF_0FFF, 32'hFEFE_0FFE,
                            32'hFDFD_0FFD, 32'hFCFC_0FFC});
   endtask

   task automatic test_basic();
      run_burst(12'd0, 13'd4, 0, 1'b0, "basic");
      run_burst(12'd2, 13'd4, 0, 1'b0, "offset");
      run_burst(12'd5, 13'd1, 0, 1'b0, "single");
   endtask

   task automatic test_backpressure();
      run_burst(12'd2, 13'd4, 1, 1'b0, "toggle_ready");
      run_burst(12'd2, 13'd10, 2, 1'b0, "long_stall");
   endtask

   task automatic test_back_to_back();
      run_burst(12'd8, 13'd8, 1, 1'b1, "start_while_busy");
      run_burst(12'd0, 13'd0, 0, 1'b0, "zero_length");
      run_burst(12'd1, 13'd3, 0, 1'b0, "after_zero");
   endtask

   task automatic test_wrap();
`ifdef NARROW_RAM_READER_ERR_EN
      int nvalid = 0;
      start      = 1'b1;
      start_addr = 12'd4094;
      length     = 13'd4;
      @(posedge clk); #1;
      start = 1'b0;
      n_chk++;
      if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0)
         $display("FAIL wrap_err: got done=%b err=%b busy=%b expected 1 1 0",
                  done, err, busy);
      else n_pass++;
      repeat (4) begin
         @(posedge clk); #1;
         if (dout_valid === 1'b1 || err === 1'b1) nvalid++;
      end
      n_chk++;
      if (nvalid != 0)
         $display("FAIL wrap_err_quiet: got %0d expected 0", nvalid);
      else n_pass++;
      run_burst(12'd4092, 13'd4, 0, 1'b0, "end_exact");
`else
      run_burst(12'd4094, 13'd4, 0, 1'b0, "wrap");
`endif
   endtask

   task automatic test_reset_mid();
      int got = 0;
      int bad = 0;
      start      = 1'b1;
      start_addr = 12'd8;
      length     = 13'd8;
      dout_ready = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 1) start = 1'b0;
         if (dout_valid === 1'b1) got++;
         if (got == 2) break;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_chk++;
      if (dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL mid_reset: got v=%b b=%b d=%b expected 0 0 0",
                  dout_valid, busy, done);
      else n_pass++;
      repeat (5) begin
         @(posedge clk); #1;
         if (done === 1'b1 || dout_valid === 1'b1 || busy === 1'b1) bad++;
      end
      n_chk++;
      if (bad != 0)
         $display("FAIL mid_reset_quiet: got %0d events expected 0", bad);
      else n_pass++;
      run_burst(12'd8, 13'd8, 0, 1'b0, "after_reset");
   endtask

   initial begin
      rst          = 1'b1;
      write_data   = '0;
      write_addr   = '0;
      write_enable = 1'b0;
      start        = 1'b0;
      start_addr   = '0;
      length       = '0;
      dout_ready   = 1'b1;
      test_reset();
      test_fill();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/narrow_ram_reader.md
NARROW_RAM_READER -- requirements
Module: narrow_ram_reader

Interface
REQ-001 Parameter DIN_WIDTH, 32, width of one narrow output word.
REQ-002 Parameter N_DIN_TO_DOUT, 4, narrow words per wide RAM word; power of 2, >=2.
REQ-003 Parameter DOUT_ADDR_WIDTH, 10, wide-word address width; LOG = log2(N_DIN_TO_DOUT), NAW = DOUT_ADDR_WIDTH+LOG.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 write_data  in  N_DIN_TO_DOUT*DIN_WIDTH  wide write word.
REQ-007 write_addr  in  DOUT_ADDR_WIDTH  wide write address.
REQ-008 write_enable  in  1  write strobe.
REQ-009 start  in  1  burst request, sampled only when busy=0.
REQ-010 start_addr  in  NAW  narrow-word address of first output word.
REQ-011 length  in  NAW+1  number of narrow words in burst.
REQ-012 busy  out  1  burst in progress.
REQ-013 dout_data  out  DIN_WIDTH  narrow output word.
REQ-014 dout_valid  out  1  dout_data valid.
REQ-015 dout_ready  in  1  downstream accepts word.
REQ-016 done  out  1  one-cycle pulse, burst finished.

Function
REQ-017 Write: write_enable=1 stores write_data at wide address write_addr; narrow address write_addr*N+i holds bits [DIN_WIDTH*(i+1)-1 : DIN_WIDTH*i].
REQ-018 RAM read is read-before-write: same-cycle write to the wide word being read returns old data.
REQ-019 FSM states IDLE, READ, DRAIN; IDLE->READ on start with length>0; READ->DRAIN when last address issued; DRAIN->IDLE on final transfer.
REQ-020 start with busy=1 is ignored; start_addr/length are captured on the accepting cycle only.
REQ-021 start with length=0: no dout_valid, done pulses the following cycle, busy stays 0.
REQ-022 busy rises the cycle after start is accepted and falls in the same cycle done is asserted.
REQ-023 Output order: start_addr, start_addr+1, ... , length words total; address arithmetic modulo 2^NAW (wrap to 0).
REQ-024 First dout_valid is asserted 2 cycles after the accepting start cycle (RAM register + output register).
REQ-025 Transfer occurs when dout_valid & dout_ready; with dout_ready held 1, one word per cycle, no bubbles.
REQ-026 While dout_valid=1 and dout_ready=0, dout_data and dout_valid hold stable; no word dropped or duplicated.
REQ-027 done pulses the cycle after the final transfer.
REQ-028 A new start is accepted in the cycle done is asserted (busy=0).

Reset
REQ-029 rst=1: FSM to IDLE, busy=0, dout_valid=0, done=0, dout_data=0, internal pipeline/skid entries invalidated.
REQ-030 rst mid-burst abandons the burst with no done pulse; RAM contents are not cleared.

Configuration
REQ-031 With NARROW_RAM_READER_ERR_EN defined: output err (1 bit) pulses one cycle when start accepted with start_addr+length > 2^NAW; burst not executed, done pulses with err, no wrap.
REQ-032 Without NARROW_RAM_READER_ERR_EN: err port absent, bursts wrap per REQ-023.

Structure
REQ-033 Shared package narrow_ram_reader_pkg holds FSM state encoding and LOG/NAW derivation functions.
REQ-034 Backpressure handled by sub-module narrow_ram_skid (2-entry skid buffer, valid/ready both sides); RAM, address counter and FSM stay in top module.

Verification
REQ-035 Write wide addr 0 = {D3,D2,D1,D0}; start addr 0 length 4, ready=1 -> D0..D3 on 4 consecutive cycles, first valid 2 cycles after start, done 1 cycle after D3.
REQ-036 Burst start_addr=2 length 4 -> words narrow 2,3,4,5 (wide 0 lanes 2,3 then wide 1 lanes 0,1).
REQ-037 Same burst, dout_ready toggled 1,0,0,1,0,1... -> data held during stalls, exact sequence, no loss/duplication.
REQ-038 start_addr=4094 length 4 (defaults, no macro) -> narrow 4094,4095,0,1; with NARROW_RAM_READER_ERR_EN -> err+done pulse, no valid.
REQ-039 length=0 -> done next cycle, no valid; start while busy -> ignored, output unchanged.
REQ-040 rst asserted after 2 of 8 words -> valid/busy 0 next cycle, no done; new burst afterwards returns correct data.
